// File: rtl/sum_serializer_64bit_if.sv
// Handshake bundle for the sum serializer: 64-bit adder result in, byte stream out.
interface sum_serializer_64bit_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] sum_in;
    logic        cout_in;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output in_valid, sum_in, cout_in, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_valid, sum_in, cout_in, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/sum_serializer_64bit.sv
// Serializes a registered 64-bit sum (plus optional carry beat) into a little-endian byte
// stream with valid/ready handshakes on both sides, counting completed frames.
module sum_serializer_64bit #(
    parameter int unsigned EMIT_CARRY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    sum_serializer_64bit_if.slave        bus,
    output logic                         busy,
    output logic [15:0]                  frame_count
);
    typedef enum logic [1:0] {StIdle, StSend, StCarry} state_e;

    localparam bit Carry = (EMIT_CARRY != 0);

    state_e      state_q, state_d;
    logic [63:0] shift_q, shift_d;
    logic        carry_q, carry_d;
    logic [2:0]  beat_q, beat_d;
    logic [15:0] frame_q, frame_d;
    logic        accept;
    logic        beat_done;
    logic        last_beat;

    assign accept    = (state_q == StIdle) && bus.in_valid;
    assign beat_done = (state_q != StIdle) && bus.out_ready;
    assign last_beat = Carry ? (state_q == StCarry)
                             : ((state_q == StSend) && (beat_q == 3'd7));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            carry_q <= 1'b0;
            beat_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            carry_q <= carry_d;
            beat_q  <= beat_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        carry_d = carry_q;
        beat_d  = beat_q;
        frame_d = frame_q;
        if (beat_done && last_beat) begin
            frame_d = frame_q + 16'd1;
        end
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d = bus.sum_in;
                    carry_d = bus.cout_in;
                    beat_d  = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                // Shifting keeps the current byte at [7:0]; stalls hold everything.
                if (beat_done) begin
                    shift_d = {8'h00, shift_q[63:8]};
                    beat_d  = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = Carry ? StCarry : StIdle;
                    end
                end
            end
            StCarry: begin
                if (beat_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q != StIdle);
        bus.out_data  = (state_q == StCarry) ? {7'b0, carry_q} : shift_q[7:0];
        bus.out_last  = last_beat;
        busy          = (state_q != StIdle);
        frame_count   = frame_q;
    end
endmodule

// File: tb/tb_sum_serializer_64bit.sv
// Checks both EMIT_CARRY variants against a queue-of-beats reference model, with table-driven
// frames, directed corner cases and randomized traffic.
module tb_sum_serializer_64bit;
    typedef struct packed {
        logic [63:0]     sum;
        logic            cout;
        logic [8:0][7:0] beats;  // index 8 = carry beat, index 0 = first byte
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] sum_in;
    logic        cout_in;
    logic        out_ready;
    logic        busy1, busy0;
    logic [15:0] fc1, fc0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    sum_serializer_64bit_if ifc1 ();
    sum_serializer_64bit_if ifc0 ();

    assign ifc1.in_valid  = in_valid;
    assign ifc1.sum_in    = sum_in;
    assign ifc1.cout_in   = cout_in;
    assign ifc1.out_ready = out_ready;
    assign ifc0.in_valid  = in_valid;
    assign ifc0.sum_in    = sum_in;
    assign ifc0.cout_in   = cout_in;
    assign ifc0.out_ready = out_ready;

    sum_serializer_64bit #(.EMIT_CARRY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(ifc1.slave), .busy(busy1), .frame_count(fc1)
    );
    sum_serializer_64bit #(.EMIT_CARRY(0)) dut0 (
        .clk(clk), .rst(rst), .bus(ifc0.slave), .busy(busy0), .frame_count(fc0)
    );

    // Inputs as seen at the rising edge, so the model advances exactly as the DUT did.
    logic        s_rst, s_iv, s_cout, s_ready, s_pre;
    logic [63:0] s_sum;
    logic        preload = 1'b0;
    always @(posedge clk) begin
        s_rst   <= rst;
        s_iv    <= in_valid;
        s_sum   <= sum_in;
        s_cout  <= cout_in;
        s_ready <= out_ready;
        s_pre   <= preload;
    end

    // Reference model: each pending beat is {last, byte}; empty queue means idle.
    logic [8:0]  q1[$];
    logic [8:0]  q0[$];
    logic [15:0] m1, m0;
    bit          started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (s_rst) begin
            q1.delete();
            q0.delete();
            m1      = '0;
            m0      = '0;
            started = 1'b1;
        end else begin
            if (s_pre) begin
                m1 = 16'hFFFF;
                m0 = 16'hFFFF;
            end
            if (q1.size() != 0) begin
                if (s_ready) begin
                    if (q1[0][8]) m1 = m1 + 16'd1;
                    void'(q1.pop_front());
                end
            end else if (s_iv) begin
                for (int k = 0; k < 8; k++) q1.push_back({1'b0, s_sum[8*k +: 8]});
                q1.push_back({1'b1, 7'b0, s_cout});
            end
            if (q0.size() != 0) begin
                if (s_ready) begin
                    if (q0[0][8]) m0 = m0 + 16'd1;
                    void'(q0.pop_front());
                end
            end else if (s_iv) begin
                for (int k = 0; k < 8; k++) q0.push_back({(k == 7), s_sum[8*k +: 8]});
            end
        end
    endtask

    task automatic model_check();
        check("m1_valid", ifc1.out_valid, q1.size() != 0);
        check("m1_in_ready", ifc1.in_ready, q1.size() == 0);
        check("m1_busy", busy1, q1.size() != 0);
        check("m1_frame_count", fc1, m1);
        if (q1.size() != 0) begin
            check("m1_data", ifc1.out_data, q1[0][7:0]);
            check("m1_last", ifc1.out_last, q1[0][8]);
        end
        check("m0_valid", ifc0.out_valid, q0.size() != 0);
        check("m0_in_ready", ifc0.in_ready, q0.size() == 0);
        check("m0_busy", busy0, q0.size() != 0);
        check("m0_frame_count", fc0, m0);
        if (q0.size() != 0) begin
            check("m0_data", ifc0.out_data, q0[0][7:0]);
            check("m0_last", ifc0.out_last, q0[0][8]);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        if (started) model_check();
    endtask

    task automatic start(input logic [63:0] s, input logic c);
        in_valid = 1'b1;
        sum_in   = s;
        cout_in  = c;
        tick();
        in_valid = 1'b0;
    endtask

    // Walks a 9-beat EMIT_CARRY=1 frame from beat 0, optionally stalling or poking new input.
    task automatic expect1(input logic [8:0][7:0] exp, input int stall_at, input int stall_n,
                           input bit poke);
        for (int b = 0; b < 9; b++) begin
            if (b == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    check("stall_data", ifc1.out_data, exp[b]);
                    check("stall_valid", ifc1.out_valid, 1'b1);
                end
                out_ready = 1'b1;
            end
            if (poke && b == 3) begin
                in_valid = 1'b1;
                sum_in   = 64'hDEAD;
                cout_in  = 1'b0;
                check("busy_in_ready", ifc1.in_ready, 1'b0);
            end
            check("beat_data", ifc1.out_data, exp[b]);
            check("beat_last", ifc1.out_last, b == 8);
            check("beat_valid", ifc1.out_valid, 1'b1);
            tick();
        end
        check("idle_in_ready", ifc1.in_ready, 1'b1);
        check("idle_valid", ifc1.out_valid, 1'b0);
    endtask

    vec_t            tbl[4];
    logic [8:0][7:0] dead_beats;
    logic [8:0][7:0] one_beats;
    logic [15:0]     exp_fc;

    initial begin
        tbl[0] = '{sum: 64'h0123456789ABCDEF, cout: 1'b1,
                   beats: {8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF}};
        tbl[1] = '{sum: 64'hFFFFFFFFFFFFFFFF, cout: 1'b1,
                   beats: {8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        tbl[2] = '{sum: 64'h0, cout: 1'b0, beats: '0};
        tbl[3] = '{sum: 64'h8000000000000001, cout: 1'b0,
                   beats: {8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}};
        dead_beats = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD};
        one_beats  = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};

        rst = 1'b1; in_valid = 1'b0; sum_in = '0; cout_in = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", ifc1.in_ready, 1'b1);
        check("rst_out_valid", ifc1.out_valid, 1'b0);
        check("rst_out_last", ifc1.out_last, 1'b0);
        check("rst_out_data", ifc1.out_data, 8'h00);
        check("rst_busy", busy1, 1'b0);
        check("rst_frame_count", fc1, 16'h0);
        check("rst0_in_ready", ifc0.in_ready, 1'b1);

        // First frame is offered in the very first cycle with rst low.
        rst    = 1'b0;
        exp_fc = 16'h0;
        for (int i = 0; i < 4; i++) begin
            start(tbl[i].sum, tbl[i].cout);
            expect1(tbl[i].beats, -1, 0, 1'b0);
            exp_fc = exp_fc + 16'd1;
            check("tbl_frame_count", fc1, exp_fc);
        end

        // EMIT_CARRY=0: eight beats, last on the eighth, idle right after.
        start(64'hFFFFFFFFFFFFFFFF, 1'b1);
        for (int b = 0; b < 8; b++) begin
            check("nc_data", ifc0.out_data, 8'hFF);
            check("nc_last", ifc0.out_last, b == 7);
            tick();
        end
        check("nc_idle_ready", ifc0.in_ready, 1'b1);
        check("nc_idle_valid", ifc0.out_valid, 1'b0);
        tick();
        exp_fc = exp_fc + 16'd1;

        // Backpressure on beat 2 for three cycles.
        start(tbl[0].sum, tbl[0].cout);
        expect1(tbl[0].beats, 2, 3, 1'b0);
        exp_fc = exp_fc + 16'd1;

        // New input offered while busy is held off until the frame ends.
        start(tbl[0].sum, tbl[0].cout);
        expect1(tbl[0].beats, -1, 0, 1'b1);
        tick();
        in_valid = 1'b0;
        expect1(dead_beats, -1, 0, 1'b0);
        exp_fc = exp_fc + 16'd2;
        check("busy_frame_count", fc1, exp_fc);

        // Reset mid-frame from a zero count, then a clean frame.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start(tbl[0].sum, tbl[0].cout);
        for (int b = 0; b < 5; b++) begin
            check("pre_rst_data", ifc1.out_data, tbl[0].beats[b]);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", ifc1.out_valid, 1'b0);
        check("midrst_busy", busy1, 1'b0);
        check("midrst_frame_count", fc1, 16'h0);
        start(64'h1, 1'b1);
        expect1(one_beats, -1, 0, 1'b0);
        check("post_rst_frame_count", fc1, 16'h1);
        tick();

        // Wrap: load 16'hFFFF into the counter, then finish one frame.
        #1;
        force dut1.frame_q = 16'hFFFF;
        force dut0.frame_q = 16'hFFFF;
        preload = 1'b1;
        @(posedge clk);
        #1;
        release dut1.frame_q;
        release dut0.frame_q;
        preload = 1'b0;
        tick();
        check("preload_count", fc1, 16'hFFFF);
        start(tbl[2].sum, tbl[2].cout);
        expect1(tbl[2].beats, -1, 0, 1'b0);
        check("wrap_count1", fc1, 16'h0000);
        check("wrap_count0", fc0, 16'h0000);

        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = $urandom_range(0, 1);
            sum_in    = {$urandom, $urandom};
            cout_in   = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int w = 0; w < 20 && !(ifc1.in_ready && ifc0.in_ready); w++) tick();
        check("drain_idle", ifc1.in_ready && ifc0.in_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
